// File: rtl/hex_display.sv
// -----------------------------------------------------------------------------
// hex_display
//   Round-robin binary-to-seven-segment converter. Each channel value is
//   snapshotted, converted to BCD by double dabble (one bit per cycle) and
//   encoded into active-low segment patterns for that channel's digits.
//   Values that do not fit in DIGITS decimal digits show a dash on every digit.
//
//   Optional feature macro: HEX_DISPLAY_LEADING_BLANK_EN
//     defined   -> leading zero digits (above the ones digit) are blanked
//     undefined -> every digit is shown, leading zeros included
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   en      conversion enable (start / continue round-robin refresh)
//   in      CHANNELS packed unsigned values, DATA_WIDTH bits each
//   hex     active-low segments {g,f,e,d,c,b,a}, 7 bits per digit, ones first
//   update  one-cycle pulse after a channel's hex slice was rewritten
//   busy    high while the converter is not idle
// -----------------------------------------------------------------------------
module hex_display #(
    parameter int DATA_WIDTH = 6,
    parameter int DIGITS     = 2,
    parameter int CHANNELS   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  in,
    output logic [CHANNELS*DIGITS*7-1:0]    hex,
    output logic                            update,
    output logic                            busy
);

    localparam int          BCD_W   = DIGITS * 4;
    localparam int          CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int          CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned MAX_VAL = (10 ** DIGITS) - 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [CH_W-1:0]               ch_idx_r;
    logic [CNT_W-1:0]              cnt_r;
    logic [DATA_WIDTH-1:0]         bin_r;
    logic [BCD_W-1:0]              bcd_r;
    logic                          ovf_r;
    logic                          update_r;
    logic                          busy_r;
    logic [CHANNELS*DIGITS*7-1:0]  hex_r;

    logic [DATA_WIDTH-1:0]         ch_val_s [CHANNELS];
    logic [DATA_WIDTH-1:0]         sel_s;
    logic [BCD_W-1:0]              bcd_adj_s;
    logic [DIGITS*7-1:0]           enc_s;
    logic [3:0]                    dig_s;
`ifdef HEX_DISPLAY_LEADING_BLANK_EN
    logic                          lead_s;
`endif

    // Seven-segment pattern for one BCD digit; non-decimal codes show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Unpack the channel values so the active one can be selected by index.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign ch_val_s[g] = in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Channel multiplexer and BCD correction for the current shift step.
    always_comb begin
        sel_s     = ch_val_s[ch_idx_r];
        bcd_adj_s = dabble_adjust(bcd_r);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: state_nxt_s = SHIFT;
            SHIFT: begin
                if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            WRITE: begin
                if (en) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Encode the finished BCD result into the segment word for one channel.
    always_comb begin
        enc_s = {(DIGITS*7){1'b1}};
        dig_s = 4'd0;
`ifdef HEX_DISPLAY_LEADING_BLANK_EN
        lead_s = 1'b1;
`endif
        for (int d = DIGITS - 1; d >= 0; d--) begin
            dig_s = bcd_r[d*4 +: 4];
            if (ovf_r) begin
                enc_s[d*7 +: 7] = SEG_DASH;
`ifdef HEX_DISPLAY_LEADING_BLANK_EN
            end else if (lead_s && (d != 0) && (dig_s == 4'd0)) begin
                enc_s[d*7 +: 7] = SEG_BLANK;
            end else begin
                lead_s          = 1'b0;
                enc_s[d*7 +: 7] = seg7(dig_s);
            end
`else
            end else begin
                enc_s[d*7 +: 7] = seg7(dig_s);
            end
`endif
        end
    end

    // FSM, channel index, and the double-dabble datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ch_idx_r <= '0;
            cnt_r    <= '0;
            bin_r    <= '0;
            bcd_r    <= '0;
            ovf_r    <= 1'b0;
            update_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s != IDLE);
            update_r <= (state_r == WRITE);
            case (state_r)
                LOAD: begin
                    bin_r <= sel_s;
                    bcd_r <= '0;
                    cnt_r <= '0;
                    ovf_r <= (32'(sel_s) > MAX_VAL);
                end
                SHIFT: begin
                    // Shifting the corrected BCD together with the binary word;
                    // any carry out of the top digit only matters on overflow.
                    {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
                    cnt_r          <= cnt_r + CNT_W'(1);
                end
                WRITE: begin
                    if (ch_idx_r == CH_W'(CHANNELS - 1)) begin
                        ch_idx_r <= '0;
                    end else begin
                        ch_idx_r <= ch_idx_r + CH_W'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Segment outputs: only the slice of the channel in WRITE is replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_r <= {(CHANNELS*DIGITS*7){1'b1}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if ((state_r == WRITE) && (ch_idx_r == CH_W'(c))) begin
                    hex_r[c*DIGITS*7 +: DIGITS*7] <= enc_s;
                end
            end
        end
    end

    assign hex    = hex_r;
    assign update = update_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_hex_display.sv
module tb_hex_display;

    localparam int BUDGET = 40;

`ifdef HEX_DISPLAY_LEADING_BLANK_EN
    localparam logic [6:0] ZL = 7'h7F;
`else
    localparam logic [6:0] ZL = 7'h40;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] in_v;
    logic [27:0] hex;
    logic        update;
    logic        busy;

    logic        en7;
    logic [13:0] in7;
    logic [27:0] hex7;
    logic        update7;
    logic        busy7;

    int n_total;
    int n_pass;

    typedef struct {
        logic [5:0]  ch0;
        logic [5:0]  ch1;
        logic [13:0] exp0;
        logic [13:0] exp1;
    } vec_t;

    vec_t vecs [5];

    hex_display #(.DATA_WIDTH(6), .DIGITS(2), .CHANNELS(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in     (in_v),
        .hex    (hex),
        .update (update),
        .busy   (busy)
    );

    hex_display #(.DATA_WIDTH(7), .DIGITS(2), .CHANNELS(2)) dut7 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en7),
        .in     (in7),
        .hex    (hex7),
        .update (update7),
        .busy   (busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait (at negedges) for an update pulse of dut (sel=0) or dut7 (sel=1).
    task automatic wait_upd(input bit sel, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            seen = sel ? update7 : update;
        end
        if (!seen) begin
            check("update_timeout", 28'd0, 28'd1);
        end
    endtask

    task automatic wait_busy();
        int  cycles;
        bit  seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            seen = busy;
        end
        if (!seen) begin
            check("busy_timeout", 28'd0, 28'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        en7   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int upd_cnt;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        en7     = 1'b0;
        in_v    = '0;
        in7     = '0;

        vecs[0] = '{6'd37, 6'd5,  {7'h30, 7'h78}, {ZL,    7'h12}};
        vecs[1] = '{6'd0,  6'd63, {ZL,    7'h40}, {7'h02, 7'h30}};
        vecs[2] = '{6'd42, 6'd19, {7'h19, 7'h24}, {7'h79, 7'h10}};
        vecs[3] = '{6'd8,  6'd56, {ZL,    7'h00}, {7'h12, 7'h02}};
        vecs[4] = '{6'd10, 6'd9,  {7'h79, 7'h40}, {ZL,    7'h10}};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_hex", hex, 28'hFFFFFFF);
        check("reset_busy", {27'd0, busy}, 28'd0);
        check("reset_update", {27'd0, update}, 28'd0);
        rst_n = 1'b1;

        // First conversion: latency and both channel slices
        @(negedge clk);
        in_v = {6'd5, 6'd37};
        en   = 1'b1;
        wait_busy();
        wait_upd(1'b0, cyc);
        check("latency_ch0", 28'(cyc), 28'd8);
        check("first_ch0_ones", {21'd0, hex[6:0]}, {21'd0, 7'h78});
        check("first_ch0_tens", {21'd0, hex[13:7]}, {21'd0, 7'h30});
        check("first_ch1_untouched", {14'd0, hex[27:14]}, {14'd0, 14'h3FFF});
        @(negedge clk);
        check("update_pulse_width", {27'd0, update}, 28'd0);
        wait_upd(1'b0, cyc);
        check("latency_ch1", 28'(cyc + 1), 28'd8);
        check("first_ch1_ones", {21'd0, hex[20:14]}, {21'd0, 7'h12});
        check("first_ch1_tens", {21'd0, hex[27:21]}, {21'd0, ZL});

        // Table-driven vectors: three updates guarantee both slices are fresh
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_v = {vecs[i].ch1, vecs[i].ch0};
            repeat (3) wait_upd(1'b0, cyc);
            check($sformatf("vec%0d_ch0", i), {14'd0, hex[13:0]}, {14'd0, vecs[i].exp0});
            check($sformatf("vec%0d_ch1", i), {14'd0, hex[27:14]}, {14'd0, vecs[i].exp1});
        end

        // Input change during SHIFT does not affect the pass in progress
        do_reset();
        @(negedge clk);
        in_v = {6'd5, 6'd37};
        en   = 1'b1;
        wait_busy();
        repeat (2) @(negedge clk);
        in_v = {6'd5, 6'd12};
        wait_upd(1'b0, cyc);
        check("snapshot_old", {14'd0, hex[13:0]}, {14'd0, 7'h30, 7'h78});
        wait_upd(1'b0, cyc);
        wait_upd(1'b0, cyc);
        check("snapshot_new", {14'd0, hex[13:0]}, {14'd0, 7'h79, 7'h24});

        // Reset during SHIFT of channel 0, then a single pass with en dropped in WRITE
        wait_upd(1'b0, cyc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_hex", hex, 28'hFFFFFFF);
        check("midreset_busy", {27'd0, busy}, 28'd0);
        check("midreset_update", {27'd0, update}, 28'd0);
        @(negedge clk);
        in_v = {6'd19, 6'd42};
        @(negedge clk);
        check("midreset_hold_hex", hex, 28'hFFFFFFF);
        rst_n = 1'b1;
        wait_busy();
        repeat (7) @(negedge clk);
        en = 1'b0;
        wait_upd(1'b0, cyc);
        check("restart_ch0_first", hex, {14'h3FFF, 7'h19, 7'h24});
        check("idle_after_write", {27'd0, busy}, 28'd0);
        upd_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (update || busy) upd_cnt++;
        end
        check("stays_idle", 28'(upd_cnt), 28'd0);

        // DATA_WIDTH=7 instance: overflow dashes and the 99/100 boundary
        @(negedge clk);
        in7 = {7'd99, 7'd120};
        en7 = 1'b1;
        repeat (3) wait_upd(1'b1, cyc);
        check("w7_latency", 28'(cyc), 28'd9);
        check("w7_ovf_ch0", {14'd0, hex7[13:0]}, {14'd0, 7'h3F, 7'h3F});
        check("w7_99_ch1", {14'd0, hex7[27:14]}, {14'd0, 7'h10, 7'h10});
        @(negedge clk);
        in7 = {7'd100, 7'd99};
        repeat (3) wait_upd(1'b1, cyc);
        check("w7_99_ch0", {14'd0, hex7[13:0]}, {14'd0, 7'h10, 7'h10});
        check("w7_100_ch1", {14'd0, hex7[27:14]}, {14'd0, 7'h3F, 7'h3F});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hex_display.md
HEX_DISPLAY -- requirements
Module: hex_display

Interface
REQ-001 Parameter DATA_WIDTH, default 6: width of each binary channel value.
REQ-002 Parameter DIGITS, default 2: decimal digits per channel.
REQ-003 Parameter CHANNELS, default 2: number of independent values displayed.
REQ-004 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  conversion enable; high starts and continues round-robin conversion.
REQ-007 in  input  CHANNELS*DATA_WIDTH  packed unsigned values; channel c occupies in[c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 hex  output  CHANNELS*DIGITS*7  active-low segments; channel c digit d occupies hex[(c*DIGITS+d)*7 +: 7], with d=0 as ones, bit order {g,f,e,d,c,b,a}.
REQ-009 update  output  1  one-cycle pulse when a channel's hex slice has just been rewritten.
REQ-010 busy  output  1  high while the FSM is outside IDLE.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT and WRITE; a channel index register SHALL select the channel in work.
REQ-012 IDLE -> LOAD when en=1; otherwise the FSM SHALL remain in IDLE.
REQ-013 LOAD (1 cycle): snapshot the selected channel into a shift register, clear the BCD accumulator, and set a flag if value > 10^DIGITS-1.
REQ-014 Input changes after LOAD SHALL NOT affect the conversion in progress.
REQ-015 SHIFT (exactly DATA_WIDTH cycles): each cycle add 3 to every BCD digit >=5, then shift {BCD, binary} left by one (double dabble).
REQ-016 WRITE (1 cycle): encode DIGITS digits into the channel's hex slice and register it; assert update in the following cycle for exactly one cycle.
REQ-017 Digit encoding SHALL be 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; blank SHALL be 7'h7F; dash SHALL be 7'h3F.
REQ-018 On overflow, every digit of that channel SHALL show dash.
REQ-019 After WRITE, the channel index SHALL increment and wrap from CHANNELS-1 to 0.
REQ-020 After WRITE, the FSM SHALL go to LOAD if en=1, else to IDLE.
REQ-021 Deasserting en mid-conversion SHALL complete the current channel through WRITE before returning to IDLE.
REQ-022 Per-channel latency SHALL be DATA_WIDTH+2 cycles from LOAD entry to WRITE exit.
REQ-023 A full refresh SHALL take CHANNELS*(DATA_WIDTH+2) cycles.
REQ-024 Slices not being written SHALL hold their value.

Reset
REQ-025 While rst_n=0: hex SHALL be all 7'h7F, update=0, busy=0, FSM in IDLE, channel index 0, BCD and shift registers cleared.
REQ-026 Reset asserted mid-conversion SHALL abort immediately with no partial slice written.
REQ-027 After release, conversion SHALL restart from channel 0.

Configuration
REQ-028 Macro HEX_DISPLAY_LEADING_BLANK_EN defined: in WRITE, non-overflow zero digits above the most significant nonzero digit SHALL be 7'h7F; digit 0 SHALL always be shown.
REQ-029 Macro HEX_DISPLAY_LEADING_BLANK_EN undefined: all digits SHALL be shown, including leading zeros.

Verification (DATA_WIDTH=6, DIGITS=2, CHANNELS=2 unless stated)
REQ-030 Reset -> hex=28'hFFFFFFF, busy=0, update=0.
REQ-031 en=1, ch0=37, ch1=5 -> first update 8 cycles after LOAD, with hex[6:0]=7'h78 and hex[13:7]=7'h30.
REQ-032 Second update -> hex[20:14]=7'h12 and hex[27:21]=7'h40 (7'h7F with HEX_DISPLAY_LEADING_BLANK_EN).
REQ-033 DATA_WIDTH=7, ch0=120 -> ch0 digits both 7'h3F; ch0=99 -> both 7'h10.
REQ-034 Change ch0 from 37 to 12 during SHIFT -> that pass shows 37; the next pass shows 12.
REQ-035 rst_n low during SHIFT, then en deasserted at WRITE -> outputs per REQ-025; after release, channel 0 converts first, and the FSM returns to IDLE (busy=0) after one WRITE.
